lsu_minibus_bridge: RTL and testbench

Load/store bridge between the rv32ima core's data-memory port and a minibus slave, such as the on-chip RAM or a peripheral behind the decoder. It accepts one CPU load or store at a time and checks alignment. It then drives a minibus request, holds it until ack, error or timeout, and returns sign- or zero-extended load data with a single-cycle done pulse. The CPU stalls while a request is outstanding.

---
 rtl/rv32ima_pkg.sv | 47 ++++
 rtl/lsu_load_ext.sv | 24 ++
 rtl/lsu_minibus_bridge.sv | 155 +++++++++++++++
 tb/tb_lsu_minibus_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32ima_pkg.sv
// Shared rv32ima types: data word, memory access width, LSU fault codes
// and the load/store bridge state encoding.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_width_t;

  typedef enum logic [1:0] {
    LSU_OK       = 2'b00,
    LSU_MISALIGN = 2'b01,
    LSU_BUSERR   = 2'b10,
    LSU_TIMEOUT  = 2'b11
  } lsu_fault_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // A request is rejected before reaching the bus when it is both a load and
  // a store, uses the reserved width code, or is not naturally aligned.
  function automatic logic lsu_access_bad(input logic       ren,
                                          input logic       wen,
                                          input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (ren && wen) begin
      bad = 1'b1;
    end else begin
      case (width)
        MEM_BYTE: bad = 1'b0;
        MEM_HALF: bad = addr_lo[0];
        MEM_WORD: bad = (addr_lo != 2'b00);
        default:  bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extension: picks the LSB-aligned byte/half/word of a raw bus
// word and sign- or zero-extends it to 32 bits. Purely combinational so it
// can also sit on cache refill paths.
module lsu_load_ext
  import rv32ima_pkg::*;
(
  input  logic [1:0] width,
  input  logic       is_unsigned,
  input  word_t      raw,
  output word_t      ext
);

  // Select the lane and replicate the sign bit unless a zero-extend is asked for.
  always_comb begin
    ext = 32'h0000_0000;
    case (width)
      MEM_BYTE: ext = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      MEM_HALF: ext = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      MEM_WORD: ext = raw;
      default:  ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_minibus_bridge.sv
// Load/store bridge from the core data port to a minibus slave. One access
// at a time: IDLE checks alignment, BUSY holds a stable bus request until
// ack/error/timeout, RESP returns a one-cycle done with bus_sel low so a
// registered-ready slave cannot leak a stale ack into the next access.
module lsu_minibus_bridge
  import rv32ima_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_unsigned,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_fault,
  output logic [1:0]  cpu_fault_cause,
  output logic        bus_sel,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_width,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] count;
  logic             unsigned_r;
  logic             req;
  word_t            ext_data;

  assign req = cpu_ren | cpu_wen;

  // The latched width/sign controls are stable through BUSY, so the
  // extender can look straight at the bus data.
  lsu_load_ext u_load_ext (
    .width       (bus_width),
    .is_unsigned (unsigned_r),
    .raw         (bus_rdata),
    .ext         (ext_data)
  );

  // Stall follows the raw request in IDLE so the core freezes in the same cycle.
  always_comb begin
    cpu_stall = 1'b0;
    if (rst) begin
      cpu_stall = 1'b0;
    end else begin
      case (state)
        IDLE:    cpu_stall = req;
        BUSY:    cpu_stall = 1'b1;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  // Bridge FSM with registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      unsigned_r      <= 1'b0;
      cpu_done        <= 1'b0;
      cpu_rdata       <= 32'h0000_0000;
      cpu_fault       <= 1'b0;
      cpu_fault_cause <= LSU_OK;
      bus_sel         <= 1'b0;
      bus_ren         <= 1'b0;
      bus_wen         <= 1'b0;
      bus_addr        <= 32'h0000_0000;
      bus_wdata       <= 32'h0000_0000;
      bus_width       <= 2'b00;
    end else begin
      // Completion outputs only carry information in the RESP cycle.
      cpu_done        <= 1'b0;
      cpu_rdata       <= 32'h0000_0000;
      cpu_fault       <= 1'b0;
      cpu_fault_cause <= LSU_OK;
      case (state)
        IDLE: begin
          if (req) begin
            if (lsu_access_bad(cpu_ren, cpu_wen, cpu_width, cpu_addr[1:0])) begin
              state           <= RESP;
              cpu_done        <= 1'b1;
              cpu_fault       <= 1'b1;
              cpu_fault_cause <= LSU_MISALIGN;
            end else begin
              state      <= BUSY;
              count      <= '0;
              bus_sel    <= 1'b1;
              bus_ren    <= cpu_ren;
              bus_wen    <= cpu_wen;
              bus_addr   <= cpu_addr;
              bus_wdata  <= cpu_wdata;
              bus_width  <= cpu_width;
              unsigned_r <= cpu_unsigned;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          count <= count + CNT_W'(1);
          if (bus_err) begin
            state           <= RESP;
            bus_sel         <= 1'b0;
            bus_ren         <= 1'b0;
            bus_wen         <= 1'b0;
            cpu_done        <= 1'b1;
            cpu_fault       <= 1'b1;
            cpu_fault_cause <= LSU_BUSERR;
          end else if (bus_ack) begin
            state     <= RESP;
            bus_sel   <= 1'b0;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_rdata <= bus_ren ? ext_data : 32'h0000_0000;
          end else if (count == CNT_LAST) begin
            state           <= RESP;
            bus_sel         <= 1'b0;
            bus_ren         <= 1'b0;
            bus_wen         <= 1'b0;
            cpu_done        <= 1'b1;
            cpu_fault       <= 1'b1;
            cpu_fault_cause <= LSU_TIMEOUT;
          end else begin
            state <= BUSY;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_sel <= 1'b0;
          bus_ren <= 1'b0;
          bus_wen <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_minibus_bridge.sv
// Directed bench for lsu_minibus_bridge: reset values, load extension,
// misaligned/illegal requests, timeout, bus error with restart, mid-access reset.
module tb_lsu_minibus_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_width;
  logic        cpu_unsigned;
  logic        cpu_stall;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_fault;
  logic [1:0]  cpu_fault_cause;
  logic        bus_sel;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_width;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_minibus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_ren         (cpu_ren),
    .cpu_wen         (cpu_wen),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_width       (cpu_width),
    .cpu_unsigned    (cpu_unsigned),
    .cpu_stall       (cpu_stall),
    .cpu_done        (cpu_done),
    .cpu_rdata       (cpu_rdata),
    .cpu_fault       (cpu_fault),
    .cpu_fault_cause (cpu_fault_cause),
    .bus_sel         (bus_sel),
    .bus_ren         (bus_ren),
    .bus_wen         (bus_wen),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_width       (bus_width),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .bus_err         (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move 1 ns past the active edge; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    cpu_width = 2'b00; cpu_unsigned = 1'b0;
    bus_rdata = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b want 0", bus_sel); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    n_checks++; if (cpu_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", cpu_done); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
    n_checks++; if (cpu_fault_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got %b want 00", cpu_fault_cause); end
    n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus_addr); end
    rst = 1'b0;
    tick();
  endtask

  // Load with a slave that acks in its 2nd selected cycle.
  task automatic do_load(input logic [1:0] w, input logic u, input logic [31:0] addr,
                         input logic [31:0] raw, input logic [31:0] exp, input string name);
    // cycle 0: request seen
    cpu_ren = 1'b1; cpu_addr = addr; cpu_width = w; cpu_unsigned = u;
    #1;
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_c0 got %b want 1", name, cpu_stall); end
    n_checks++; if (bus_sel !== 1'b0) begin n_fail++; $display("FAIL %s_sel_c0 got %b want 0", name, bus_sel); end
    tick();
    // cycle 1: first selected cycle, CPU inputs changed and must be ignored
    cpu_ren = 1'b0; cpu_addr = 32'hFFFF_FFFF; cpu_width = 2'b11;
    #1;
    n_checks++; if (bus_sel !== 1'b1 || bus_ren !== 1'b1 || bus_wen !== 1'b0) begin n_fail++; $display("FAIL %s_bus_c1 got sel=%b ren=%b wen=%b want 1 1 0", name, bus_sel, bus_ren, bus_wen); end
    n_checks++; if (bus_addr !== addr || bus_width !== w) begin n_fail++; $display("FAIL %s_addr_c1 got %h/%b want %h/%b", name, bus_addr, bus_width, addr, w); end
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_c1 got %b want 1", name, cpu_stall); end
    tick();
    // cycle 2: slave acks
    bus_ack = 1'b1; bus_rdata = raw;
    #1;
    n_checks++; if (bus_sel !== 1'b1 || cpu_stall !== 1'b1 || cpu_done !== 1'b0) begin n_fail++; $display("FAIL %s_c2 got sel=%b stall=%b done=%b want 1 1 0", name, bus_sel, cpu_stall, cpu_done); end
    n_checks++; if (bus_addr !== addr) begin n_fail++; $display("FAIL %s_addr_c2 got %h want %h", name, bus_addr, addr); end
    tick();
    // cycle 3: completion
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    n_checks++; if (cpu_done !== 1'b1 || cpu_fault !== 1'b0) begin n_fail++; $display("FAIL %s_done_c3 got done=%b fault=%b want 1 0", name, cpu_done, cpu_fault); end
    n_checks++; if (cpu_rdata !== exp) begin n_fail++; $display("FAIL %s_rdata got %h want %h", name, cpu_rdata, exp); end
    n_checks++; if (bus_sel !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL %s_c3 got sel=%b stall=%b want 0 0", name, bus_sel, cpu_stall); end
    tick();
    n_checks++; if (cpu_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_c4 got %b want 0", name, cpu_done); end
    idle_inputs();
  endtask

  task automatic test_loads();
    do_load(2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");
    do_load(2'b00, 1'b0, 32'h0000_0103, 32'h0000_0080, 32'hFFFF_FF80, "lb");
    do_load(2'b00, 1'b1, 32'h0000_0103, 32'h0000_0080, 32'h0000_0080, "lbu");
    do_load(2'b01, 1'b0, 32'h0000_0102, 32'h0000_8001, 32'hFFFF_8001, "lh");
    do_load(2'b01, 1'b1, 32'h0000_0102, 32'hFFFF_8001, 32'h0000_8001, "lhu");
    do_load(2'b00, 1'b0, 32'h0000_0101, 32'h1234_567F, 32'h0000_007F, "lb_pos");
  endtask

  task automatic test_misalign(input logic r, input logic wr, input logic [1:0] w,
                               input logic [31:0] addr, input string name);
    cpu_ren = r; cpu_wen = wr; cpu_width = w; cpu_addr = addr; cpu_wdata = 32'hA5A5_A5A5;
    #1;
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall got %b want 1", name, cpu_stall); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (cpu_done !== 1'b1 || cpu_fault !== 1'b1) begin n_fail++; $display("FAIL %s_done got done=%b fault=%b want 1 1", name, cpu_done, cpu_fault); end
    n_checks++; if (cpu_fault_cause !== 2'b01) begin n_fail++; $display("FAIL %s_cause got %b want 01", name, cpu_fault_cause); end
    n_checks++; if (bus_sel !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL %s_bus got sel=%b rdata=%h want 0 0", name, bus_sel, cpu_rdata); end
    tick();
    n_checks++; if (cpu_done !== 1'b0 || bus_sel !== 1'b0) begin n_fail++; $display("FAIL %s_after got done=%b sel=%b want 0 0", name, cpu_done, bus_sel); end
  endtask

  task automatic test_timeout();
    int sel_cnt;
    bit seen;
    sel_cnt = 0;
    seen = 1'b0;
    cpu_ren = 1'b1; cpu_width = 2'b10; cpu_addr = 32'h0000_0200;
    tick();
    idle_inputs();
    for (int i = 0; i < 40; i++) begin
      if (cpu_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus_sel === 1'b1) sel_cnt++;
      tick();
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL timeout_done got %b want 1 within 40 cycles", seen); end
    n_checks++; if (sel_cnt != 16) begin n_fail++; $display("FAIL timeout_sel_cycles got %0d want 16", sel_cnt); end
    n_checks++; if (cpu_fault !== 1'b1 || cpu_fault_cause !== 2'b11) begin n_fail++; $display("FAIL timeout_cause got fault=%b cause=%b want 1 11", cpu_fault, cpu_fault_cause); end
    n_checks++; if (bus_sel !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_resp got sel=%b rdata=%h want 0 0", bus_sel, cpu_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    // Store held continuously; first attempt hits a bus error.
    cpu_wen = 1'b1; cpu_width = 2'b10; cpu_addr = 32'h0000_0300; cpu_wdata = 32'h1234_5678;
    tick();
    bus_err = 1'b1;
    #1;
    n_checks++; if (bus_sel !== 1'b1 || bus_wen !== 1'b1 || bus_ren !== 1'b0) begin n_fail++; $display("FAIL err_bus got sel=%b wen=%b ren=%b want 1 1 0", bus_sel, bus_wen, bus_ren); end
    n_checks++; if (bus_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL err_wdata got %h want 12345678", bus_wdata); end
    tick();
    bus_err = 1'b0;
    #1;
    n_checks++; if (cpu_done !== 1'b1 || cpu_fault !== 1'b1 || cpu_fault_cause !== 2'b10) begin n_fail++; $display("FAIL err_done got done=%b fault=%b cause=%b want 1 1 10", cpu_done, cpu_fault, cpu_fault_cause); end
    n_checks++; if (bus_sel !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL err_resp got sel=%b stall=%b want 0 0", bus_sel, cpu_stall); end
    tick();
    #1;
    n_checks++; if (bus_sel !== 1'b0 || cpu_stall !== 1'b1 || cpu_done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got sel=%b stall=%b done=%b want 0 1 0", bus_sel, cpu_stall, cpu_done); end
    tick();
    // Second attempt of the held store, acked on its first selected cycle.
    cpu_wen = 1'b0;
    bus_ack = 1'b1;
    #1;
    n_checks++; if (bus_sel !== 1'b1 || bus_wen !== 1'b1 || bus_addr !== 32'h0000_0300) begin n_fail++; $display("FAIL b2b_restart got sel=%b wen=%b addr=%h want 1 1 00000300", bus_sel, bus_wen, bus_addr); end
    tick();
    bus_ack = 1'b0;
    #1;
    n_checks++; if (cpu_done !== 1'b1 || cpu_fault !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_done got done=%b fault=%b rdata=%h want 1 0 0", cpu_done, cpu_fault, cpu_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_midbusy();
    cpu_ren = 1'b1; cpu_width = 2'b10; cpu_addr = 32'h0000_0400;
    tick();
    cpu_ren = 1'b0;
    #1;
    n_checks++; if (bus_sel !== 1'b1) begin n_fail++; $display("FAIL rstbusy_sel_c1 got %b want 1", bus_sel); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus_sel !== 1'b0 || cpu_stall !== 1'b0 || cpu_done !== 1'b0) begin n_fail++; $display("FAIL rstbusy_after got sel=%b stall=%b done=%b want 0 0 0", bus_sel, cpu_stall, cpu_done); end
    tick();
    n_checks++; if (cpu_done !== 1'b0 || bus_sel !== 1'b0) begin n_fail++; $display("FAIL rstbusy_next got done=%b sel=%b want 0 0", cpu_done, bus_sel); end
    do_load(2'b10, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D, "lw_after_rst");
  endtask

  initial begin
    test_reset();
    test_loads();
    test_misalign(1'b0, 1'b1, 2'b01, 32'h0000_0101, "sh_misalign");
    test_misalign(1'b1, 1'b0, 2'b11, 32'h0000_0100, "width11");
    test_misalign(1'b1, 1'b1, 2'b10, 32'h0000_0100, "ren_wen");
    test_misalign(1'b1, 1'b0, 2'b10, 32'h0000_0102, "lw_misalign");
    test_timeout();
    test_back_to_back();
    test_reset_midbusy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
